// File: rtl/capture_sequencer.sv
// Run-control sequencer for the capture chain: arm, trigger, decimated capture
// into the logging BRAM, then readout.
module capture_sequencer #(
  parameter int NB_ADDR = 10,
  parameter int NB_DATA = 8,
  parameter int NB_DEC  = 4
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_arm,
  input  logic               i_stop,
  input  logic [1:0]         i_trig_mode,
  input  logic [NB_DATA-1:0] i_threshold,
  input  logic [NB_DEC-1:0]  i_decim,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_data_valid,
  input  logic               i_rd_req,
  output logic               o_gen_enable,
  output logic               o_ram_we,
  output logic [NB_ADDR-1:0] o_ram_waddr,
  output logic [NB_DATA-1:0] o_ram_wdata,
  output logic [NB_ADDR-1:0] o_ram_raddr,
  output logic               o_full,
  output logic [1:0]         o_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_FULL    = 2'b11
  } state_t;

  localparam logic [NB_ADDR-1:0] ONE_ADDR  = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR-1:0] LAST_ADDR = {NB_ADDR{1'b1}};
  localparam logic [NB_DEC-1:0]  ONE_DEC   = {{(NB_DEC-1){1'b0}}, 1'b1};

  state_t                     state_q, state_d;
  logic                       arm_q;
  logic signed [NB_DATA-1:0]  prev_q, prev_d;
  logic                       prev_ok_q, prev_ok_d;
  logic [NB_DEC-1:0]          dec_q, dec_d;
  logic                       gen_q, gen_d;
  logic                       we_q, we_d;
  logic [NB_ADDR-1:0]         waddr_q, waddr_d;
  logic [NB_DATA-1:0]         wdata_q, wdata_d;
  logic [NB_ADDR-1:0]         raddr_q, raddr_d;
  logic                       full_q, full_d;
  logic                       arm_edge;
  logic                       trig;
  logic                       rise_hit;
  logic                       fall_hit;

  // Next-state and output decode
  always_comb begin
    arm_edge  = i_arm & ~arm_q;
    rise_hit  = prev_ok_q && (prev_q < $signed(i_threshold)) && ($signed(i_data) >= $signed(i_threshold));
    fall_hit  = prev_ok_q && (prev_q > $signed(i_threshold)) && ($signed(i_data) <= $signed(i_threshold));
    case (i_trig_mode)
      2'b01:   trig = rise_hit;
      2'b10:   trig = fall_hit;
      default: trig = 1'b1;
    endcase

    state_d   = state_q;
    prev_d    = prev_q;
    prev_ok_d = prev_ok_q;
    dec_d     = dec_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    raddr_d   = raddr_q;
    full_d    = full_q;

    if (i_stop) begin
      state_d = ST_IDLE;
      full_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arm_edge) begin
            state_d   = ST_ARMED;
            waddr_d   = '0;
            dec_d     = '0;
            prev_ok_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (i_data_valid) begin
            prev_d    = i_data;
            prev_ok_d = 1'b1;
            if (trig) begin
              state_d = ST_CAPTURE;
              we_d    = 1'b1;
              waddr_d = '0;
              wdata_d = i_data;
              dec_d   = '0;
            end else begin
              state_d = ST_ARMED;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (i_data_valid) begin
            // >= keeps a lowered i_decim from stranding the counter above it
            if (dec_q >= i_decim) begin
              dec_d   = '0;
              we_d    = 1'b1;
              waddr_d = waddr_q + ONE_ADDR;
              wdata_d = i_data;
              if (waddr_q + ONE_ADDR == LAST_ADDR) begin
                state_d = ST_FULL;
                full_d  = 1'b1;
                raddr_d = '0;
              end else begin
                state_d = ST_CAPTURE;
              end
            end else begin
              dec_d = dec_q + ONE_DEC;
            end
          end else begin
            state_d = ST_CAPTURE;
          end
        end
        ST_FULL: begin
          if (arm_edge) begin
            state_d   = ST_ARMED;
            full_d    = 1'b0;
            raddr_d   = '0;
            waddr_d   = '0;
            dec_d     = '0;
            prev_ok_d = 1'b0;
          end else if (i_rd_req) begin
            raddr_d = raddr_q + ONE_ADDR;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    gen_d = (state_d == ST_ARMED) || (state_d == ST_CAPTURE);
  end

  // State and registered outputs
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q   <= ST_IDLE;
      arm_q     <= 1'b0;
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
      dec_q     <= '0;
      gen_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      full_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_q     <= i_arm;
      prev_q    <= prev_d;
      prev_ok_q <= prev_ok_d;
      dec_q     <= dec_d;
      gen_q     <= gen_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      raddr_q   <= raddr_d;
      full_q    <= full_d;
    end
  end

  assign o_gen_enable = gen_q;
  assign o_ram_we     = we_q;
  assign o_ram_waddr  = waddr_q;
  assign o_ram_wdata  = wdata_q;
  assign o_ram_raddr  = raddr_q;
  assign o_full       = full_q;
  assign o_state      = state_q;

endmodule
